usb_packet_receiver: RTL and testbench

- USB-style serial packet receiver: recovers NRZI bits from the d_plus/d_minus pair at 8 clocks per bit.
- Checks SYNC and PID, and stores payload bytes in an internal FIFO.
- Reports packet activity, errors and the last PID to a host-side byte reader. Sits between the bus pins and the protocol layer.

---
 rtl/usb_packet_receiver.sv | 206 ++++++++++++++++++++
 tb/tb_usb_packet_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_receiver.sv
// NRZI serial packet receiver with SYNC/PID checking and a payload FIFO.
// Optional bit-stuffing removal is built when BIT_STUFF_EN is defined.
module usb_packet_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       r_enable,
    output logic [7:0] r_data,
    output logic       empty,
    output logic       full,
    output logic       rcving,
    output logic       r_error,
    output logic [3:0] PID
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE, SYNC_RCV, PID_RCV, DATA_RCV, EOP_WAIT, ERR_WAIT
    } state_e;

    state_e        state_q;
    logic          dp_m_q, dp_q, dpp_q, dm_m_q, dm_q;
    logic [CW-1:0] cnt_q;
    logic          last_q;
    logic [7:0]    sh_q;
    logic [2:0]    nb_q;
    logic          rcving_q, err_q, wr_q;
    logic [3:0]    pid_q;
    logic [7:0]    wdat_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   fcnt_q;

    logic       dp_edge, dp_fall, sample, se0, bit_d, pid_ok, rd;
    logic [7:0] byte_d;
    logic       stuff_skip, stuff_err;

    assign dp_edge = dp_q ^ dpp_q;
    assign dp_fall = dpp_q & ~dp_q;
    assign sample  = (cnt_q == CW'(3));
    assign se0     = ~dp_q & ~dm_q;
    assign bit_d   = (dp_q == last_q);
    assign byte_d  = {bit_d, sh_q[7:1]};
    assign pid_ok  = (byte_d[7:4] == ~byte_d[3:0]) &&
                     (byte_d[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD, 4'h3,
                                          4'hB, 4'h2, 4'hA, 4'hE});

    always_ff @(posedge clk) begin
        if (n_rst) begin
            dp_m_q <= 1'b1;
            dp_q   <= 1'b1;
            dpp_q  <= 1'b1;
            dm_m_q <= 1'b0;
            dm_q   <= 1'b0;
        end else begin
            dp_m_q <= d_plus;
            dp_q   <= dp_m_q;
            dpp_q  <= dp_q;
            dm_m_q <= d_minus;
            dm_q   <= dm_m_q;
        end
    end

    // Bit clock re-aligns to every D+ transition
    always_ff @(posedge clk) begin
        if (n_rst || dp_edge || cnt_q == CW'(CLKS_PER_BIT - 1))
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

`ifdef BIT_STUFF_EN
    logic [2:0] ones_q;
    logic       collect, take;
    assign collect    = (state_q == SYNC_RCV) || (state_q == PID_RCV) ||
                        (state_q == DATA_RCV);
    assign take       = collect && sample && !se0;
    assign stuff_skip = (ones_q == 3'd6);
    assign stuff_err  = stuff_skip & bit_d;

    always_ff @(posedge clk) begin
        if (n_rst || !collect)
            ones_q <= '0;
        else if (take)
            ones_q <= (stuff_skip || !bit_d) ? 3'd0 : ones_q + 3'd1;
    end
`else
    assign stuff_skip = 1'b0;
    assign stuff_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            sh_q     <= '0;
            nb_q     <= '0;
            rcving_q <= 1'b0;
            err_q    <= 1'b0;
            pid_q    <= '0;
            wr_q     <= 1'b0;
            wdat_q   <= '0;
        end else begin
            wr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    last_q <= 1'b1;
                    nb_q   <= '0;
                    if (dp_fall) begin
                        state_q  <= SYNC_RCV;
                        rcving_q <= 1'b1;
                        err_q    <= 1'b0;
                    end
                end
                SYNC_RCV, PID_RCV, DATA_RCV: begin
                    if (sample && se0) begin
                        state_q <= EOP_WAIT;
                        if (state_q != DATA_RCV || nb_q != 3'd0)
                            err_q <= 1'b1;
                    end else if (sample) begin
                        last_q <= dp_q;
                        if (stuff_err) begin
                            err_q   <= 1'b1;
                            state_q <= ERR_WAIT;
                        end else if (!stuff_skip) begin
                            sh_q <= byte_d;
                            nb_q <= nb_q + 3'd1;
                            if (nb_q == 3'd7) begin
                                if (state_q == SYNC_RCV) begin
                                    if (byte_d == 8'h80) begin
                                        state_q <= PID_RCV;
                                    end else begin
                                        err_q   <= 1'b1;
                                        state_q <= ERR_WAIT;
                                    end
                                end else if (state_q == PID_RCV) begin
                                    if (pid_ok) begin
                                        pid_q   <= byte_d[3:0];
                                        state_q <= DATA_RCV;
                                    end else begin
                                        err_q   <= 1'b1;
                                        state_q <= ERR_WAIT;
                                    end
                                end else if (full) begin
                                    err_q <= 1'b1;
                                end else begin
                                    wr_q   <= 1'b1;
                                    wdat_q <= byte_d;
                                end
                            end
                        end
                    end
                end
                EOP_WAIT: begin
                    if (dp_q) begin
                        state_q  <= IDLE;
                        rcving_q <= 1'b0;
                    end
                end
                ERR_WAIT: begin
                    if (sample && se0)
                        state_q <= EOP_WAIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd = r_enable && (fcnt_q != '0);

    always_ff @(posedge clk) begin
        if (wr_q)
            mem_q[wp_q] <= wdat_q;
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (wr_q)
                wp_q <= wp_q + AW'(1);
            if (rd)
                rp_q <= rp_q + AW'(1);
            if (wr_q && !rd)
                fcnt_q <= fcnt_q + (AW+1)'(1);
            else if (!wr_q && rd)
                fcnt_q <= fcnt_q - (AW+1)'(1);
        end
    end

    assign empty   = (fcnt_q == '0);
    assign full    = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign r_data  = empty ? 8'h00 : mem_q[rp_q];
    assign rcving  = rcving_q;
    assign r_error = err_q;
    assign PID     = pid_q;

endmodule

// File: tb/tb_usb_packet_receiver.sv
// Directed bench for usb_packet_receiver with a packet-level reference model.
// Default build only: stimulus never carries stuffed bits.
module tb_usb_packet_receiver;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b0;
    logic       r_enable = 1'b0;
    logic [7:0] r_data;
    logic       empty, full, rcving, r_error;
    logic [3:0] PID;

    usb_packet_receiver #(.CLKS_PER_BIT(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
        .r_enable(r_enable), .r_data(r_data), .empty(empty), .full(full),
        .rcving(rcving), .r_error(r_error), .PID(PID)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mq[$];
    logic       m_err = 1'b0;
    logic [3:0] m_pid = 4'h0;
    bit         chk_en = 1'b0;
    bit         pk[$];
    logic       lvl = 1'b1;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("empty", empty, mq.size() == 0);
            cmp("full", full, mq.size() == DEPTH);
            cmp("r_data", r_data, (mq.size() != 0) ? mq[0] : 8'h00);
            cmp("r_error", r_error, m_err);
            cmp("PID", PID, m_pid);
            cmp("rcving", rcving, 1'b0);
        end
    end

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = pk[base + j];
        return v;
    endfunction

    // Outcome of one packet from its decoded bit list, then EOP
    task automatic model_packet();
        int n;
        logic [7:0] b;
        n = pk.size();
        m_err = 1'b0;
        if (n < 8 || get_byte(0) != 8'h80 || n < 16) begin
            m_err = 1'b1;
            return;
        end
        b = get_byte(8);
        if (!(b[7:4] == ~b[3:0] && b[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD,
              4'h3, 4'hB, 4'h2, 4'hA, 4'hE})) begin
            m_err = 1'b1;
            return;
        end
        m_pid = b[3:0];
        for (int k = 16; k + 8 <= n; k += 8) begin
            if (mq.size() == DEPTH) m_err = 1'b1;
            else mq.push_back(get_byte(k));
        end
        if ((n - 16) % 8 != 0) m_err = 1'b1;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int j = 0; j < 8; j++) pk.push_back(b[j]);
    endtask

    task automatic drive_bit(input bit b);
        if (!b) lvl = ~lvl;
        d_plus = lvl;
        d_minus = ~lvl;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input bit settle);
        chk_en = 1'b0;
        for (int i = 0; i < pk.size(); i++) begin
            if (i == 4) begin
                cmp("rcving_start", rcving, 1'b1);
                cmp("err_clr_start", r_error, 1'b0);
            end
            drive_bit(pk[i]);
        end
        d_plus = 1'b0;
        d_minus = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        lvl = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        model_packet();
        pk.delete();
        if (settle) begin
            for (int k = 0; k < 40 && rcving; k++) @(posedge clk);
            #1;
            cmp("rcving_timeout", rcving, 1'b0);
            repeat (4) @(posedge clk);
            #1;
            chk_en = 1'b1;
        end
    endtask

    task automatic pop();
        r_enable = 1'b1;
        @(posedge clk);
        #1;
        r_enable = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        n_rst = 1'b1;
        lvl = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
        m_pid = 4'h0;
    endtask

    initial begin
        #1;
        do_reset();
        cmp("rst_empty", empty, 1'b1);
        cmp("rst_full", full, 1'b0);
        cmp("rst_rcving", rcving, 1'b0);
        cmp("rst_err", r_error, 1'b0);
        cmp("rst_pid", PID, 4'h0);
        cmp("rst_rdata", r_data, 8'h00);
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        add_byte(8'h80); add_byte(8'hE1); add_byte(8'h55);
        send_pkt(1'b1);
        cmp("a_pid", PID, 4'h1);
        cmp("a_err", r_error, 1'b0);
        cmp("a_data", r_data, 8'h55);
        pop();
        cmp("a_empty", empty, 1'b1);

        add_byte(8'h80); add_byte(8'hE1);
        add_byte(8'h00); add_byte(8'h40); add_byte(8'h61);
        send_pkt(1'b1);
        cmp("b_rd0", r_data, 8'h00);
        pop();
        cmp("b_rd1", r_data, 8'h40);
        pop();
        cmp("b_rd2", r_data, 8'h61);
        pop();
        cmp("b_empty", empty, 1'b1);

        add_byte(8'h00); add_byte(8'hE1); add_byte(8'h55);
        send_pkt(1'b1);
        cmp("c_err", r_error, 1'b1);
        cmp("c_empty", empty, 1'b1);

        add_byte(8'h80); add_byte(8'hE1);
        for (int i = 0; i < 5; i++) pk.push_back(1'b0);
        send_pkt(1'b1);
        cmp("d_err", r_error, 1'b1);
        cmp("d_empty", empty, 1'b1);
        add_byte(8'h80);
        send_pkt(1'b1);
        cmp("d_err2", r_error, 1'b1);

        add_byte(8'h80); add_byte(8'h0F); add_byte(8'h81);
        send_pkt(1'b1);
        cmp("e_err", r_error, 1'b1);
        cmp("e_pid", PID, 4'h1);
        cmp("e_empty", empty, 1'b1);

        add_byte(8'h80); add_byte(8'hD2);
        send_pkt(1'b0);
        add_byte(8'h80); add_byte(8'hE1); add_byte(8'h81);
        send_pkt(1'b1);
        cmp("f_err", r_error, 1'b0);
        cmp("f_data", r_data, 8'h81);
        pop();

        add_byte(8'h80); add_byte(8'hE1);
        for (int i = 1; i <= 9; i++) add_byte(8'(i));
        send_pkt(1'b1);
        cmp("g_full", full, 1'b1);
        cmp("g_err", r_error, 1'b1);
        cmp("g_head", r_data, 8'h01);
        for (int i = 0; i < DEPTH; i++) pop();
        cmp("g_empty", empty, 1'b1);
        pop();
        cmp("g_empty_rd", r_data, 8'h00);

        add_byte(8'h80); add_byte(8'hE1); add_byte(8'h42);
        send_pkt(1'b1);
        add_byte(8'h80); add_byte(8'hE1);
        chk_en = 1'b0;
        for (int i = 0; i < pk.size(); i++) drive_bit(pk[i]);
        pk.delete();
        cmp("h_mid_rcv", rcving, 1'b1);
        do_reset();
        cmp("h_rcving", rcving, 1'b0);
        cmp("h_empty", empty, 1'b1);
        cmp("h_pid", PID, 4'h0);
        repeat (4) @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
